// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: address/line widths, line tags and the
// write-back buffer state encoding, plus the tag-to-address alignment helper.
package lc3b_types;

  localparam int ADDR_W   = 16;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - OFFSET_W;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [TAG_W-1:0]  lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    MEM_READ,
    RESPOND
  } wb_state_t;

  // Rebuild a line-aligned byte address from a line tag.
  function automatic lc3b_word lineAddr(input lc3b_line_tag tag);
    return {tag, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_writeback_buffer.sv
// Single-entry victim buffer between the cache pmem port and physical memory:
// absorbs evictions quickly, drains them when idle, and forwards reads that hit.
module cache_writeback_buffer
  import lc3b_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cache_address,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [LINE_W-1:0] cache_wdata,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              cache_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  wb_state_t    r_state;
  logic         r_bufValid;
  lc3b_line_tag r_bufTag;
  lc3b_line     r_bufData;

  lc3b_line     r_cacheRdata;
  logic         r_cacheResp;
  lc3b_word     r_pmemAddress;
  logic         r_pmemRead;
  logic         r_pmemWrite;
  lc3b_line     r_pmemWdata;

  lc3b_line_tag          w_reqTag;
  logic                  w_hit;
  logic [OFFSET_W-1:0]   w_unusedOffset;

  assign w_reqTag       = cache_address[ADDR_W-1:OFFSET_W];
  assign w_unusedOffset = cache_address[OFFSET_W-1:0];
  assign w_hit          = r_bufValid && (r_bufTag == w_reqTag);

  // All outputs are registered and change only on state transitions, so the
  // memory strobes can never overlap and cache_resp is high only in RESPOND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bufValid    <= 1'b0;
      r_bufTag      <= '0;
      r_bufData     <= '0;
      r_cacheRdata  <= '0;
      r_cacheResp   <= 1'b0;
      r_pmemAddress <= '0;
      r_pmemRead    <= 1'b0;
      r_pmemWrite   <= 1'b0;
      r_pmemWdata   <= '0;
    end else begin
      r_cacheResp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cache_write && !r_bufValid) begin
            r_bufTag    <= w_reqTag;
            r_bufData   <= cache_wdata;
            r_bufValid  <= 1'b1;
            r_cacheResp <= 1'b1;
            r_state     <= RESPOND;
          end else if (cache_write) begin
            // Old victim must reach memory first; the write is retried from IDLE.
            r_pmemWrite   <= 1'b1;
            r_pmemAddress <= lineAddr(r_bufTag);
            r_pmemWdata   <= r_bufData;
            r_state       <= DRAIN;
          end else if (cache_read && w_hit) begin
            r_cacheRdata <= r_bufData;
            r_cacheResp  <= 1'b1;
            r_state      <= RESPOND;
          end else if (cache_read) begin
            r_pmemRead    <= 1'b1;
            r_pmemAddress <= lineAddr(w_reqTag);
            r_state       <= MEM_READ;
          end else if (r_bufValid) begin
            r_pmemWrite   <= 1'b1;
            r_pmemAddress <= lineAddr(r_bufTag);
            r_pmemWdata   <= r_bufData;
            r_state       <= DRAIN;
          end
        end

        DRAIN: begin
          if (pmem_resp) begin
            r_pmemWrite <= 1'b0;
            r_bufValid  <= 1'b0;
            r_state     <= IDLE;
          end
        end

        MEM_READ: begin
          if (pmem_resp) begin
            r_pmemRead   <= 1'b0;
            r_cacheRdata <= pmem_rdata;
            r_cacheResp  <= 1'b1;
            r_state      <= RESPOND;
          end
        end

        RESPOND: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cache_rdata  = r_cacheRdata;
  assign cache_resp   = r_cacheResp;
  assign pmem_address = r_pmemAddress;
  assign pmem_read    = r_pmemRead;
  assign pmem_write   = r_pmemWrite;
  assign pmem_wdata   = r_pmemWdata;

endmodule
